// File: rtl/riscv_pkg.sv
// riscv_pkg: constants and enumerations shared by the RV32M execution unit.
//   XLEN          operand/result width (also the iteration count)
//   CNT_W         width of the iteration counter
//   m_funct3_e    RV32M funct3 encodings
//   muldiv_state_e control states of the multiply/divide unit
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } m_funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
//   Multiply is shift-add, divide is restoring; both work on unsigned
//   magnitudes in a shared 2*XLEN accumulator, one bit per RUN cycle, and the
//   signs are applied in FIX.  Divide-by-zero and signed overflow skip RUN.
// Ports:
//   clk     core clock
//   rst_n   asynchronous active-low reset
//   start   request pulse, accepted only in IDLE or DONE
//   funct3  RV32M operation select
//   op_a    rs1 value
//   op_b    rs2 value
//   busy    high in RUN and FIX
//   done    one-cycle pulse, result valid
//   result  registered result, held until the next completion
module muldiv_unit
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  muldiv_state_e       state_q, state_d;
  m_funct3_e           funct3_q, funct3_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic                neg_q, neg_d;    // product / quotient sign
  logic                rneg_q, rneg_d;  // remainder sign
  logic                fast_q, fast_d;  // accumulator low half already holds the result
  logic [XLEN-1:0]     result_q, result_d;

  // Operand decode for the request being presented.
  m_funct3_e       f3_in;
  logic            in_div, in_rem, sgn_a_op, sgn_b_op, sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf, accept;

  assign f3_in    = m_funct3_e'(funct3);
  assign in_div   = funct3[2];
  assign in_rem   = funct3[2] & funct3[1];
  assign sgn_a_op = (f3_in == F3_MUL) || (f3_in == F3_MULH) || (f3_in == F3_MULHSU) ||
                    (f3_in == F3_DIV) || (f3_in == F3_REM);
  assign sgn_b_op = (f3_in == F3_MUL) || (f3_in == F3_MULH) ||
                    (f3_in == F3_DIV) || (f3_in == F3_REM);
  assign sa       = sgn_a_op & op_a[XLEN-1];
  assign sb       = sgn_b_op & op_b[XLEN-1];
  assign mag_a    = sa ? (~op_a + 1'b1) : op_a;
  assign mag_b    = sb ? (~op_b + 1'b1) : op_b;
  assign div_zero = in_div && (op_b == '0);
  assign div_ovf  = in_div && sgn_a_op && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
  assign accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // Shift-add step: add the multiplicand into the high half when the current
  // multiplier bit (acc[0]) is set, then shift the whole register right. The
  // carry out of the add becomes the new top bit.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? b_q : {XLEN{1'b0}})};
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Restoring step: high half is the partial remainder, low half shifts the
  // dividend out at the top and the quotient in at the bottom. The partial
  // remainder stays below the divisor, so XLEN+1 bits hold the shifted value
  // and the top bit of the difference is the borrow.
  logic [XLEN:0]     div_sh, div_diff;
  logic              div_ok;
  logic [2*XLEN-1:0] div_next;
  assign div_sh   = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff = div_sh - {1'b0, b_q};
  assign div_ok   = ~div_diff[XLEN];
  assign div_next = {(div_ok ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]),
                     acc_q[XLEN-2:0], div_ok};

  // Sign-corrected results available in FIX.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  assign prod_fix = neg_q  ? (~acc_q + 1'b1) : acc_q;
  assign quo_fix  = neg_q  ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
  assign rem_fix  = rneg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    cnt_d    = cnt_q;
    b_d      = b_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    fast_d   = fast_q;
    result_d = result_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          funct3_d = f3_in;
          b_d      = mag_b;
          cnt_d    = '0;
          neg_d    = sa ^ sb;
          rneg_d   = sa;
          fast_d   = 1'b0;
          acc_d    = {{XLEN{1'b0}}, mag_a};
          state_d  = ST_RUN;
          if (div_zero) begin
            fast_d  = 1'b1;
            acc_d   = {{XLEN{1'b0}}, (in_rem ? op_a : {XLEN{1'b1}})};
            state_d = ST_FIX;
          end else if (div_ovf) begin
            fast_d  = 1'b1;
            acc_d   = {{XLEN{1'b0}}, (in_rem ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}})};
            state_d = ST_FIX;
          end
        end
      end

      ST_RUN: begin
        acc_d = funct3_q[2] ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        state_d = ST_DONE;
        if (fast_q) begin
          result_d = acc_q[XLEN-1:0];
        end else begin
          case (funct3_q)
            F3_MUL:                       result_d = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              result_d = quo_fix;
            default:                      result_d = rem_fix;
          endcase
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      funct3_q <= F3_MUL;
      cnt_q    <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      fast_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      cnt_q    <= cnt_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      fast_q   <= fast_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == ST_RUN) || (state_q == ST_FIX);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide execution unit for the multicycle core. Sits directly downstream of the register file: operands come from the two register-file read ports, and the result goes back through the core's writeback mux into the register-file write port. The control FSM starts an operation, waits on busy/done, then writes back result.

Parameters:
XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
clk  in  1  core clock, all state updates on posedge
rst_n  in  1  asynchronous active-low reset
start  in  1  request pulse; sampled only in IDLE or DONE
funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  in  XLEN  rs1 value (register-file read port 0)
op_b  in  XLEN  rs2 value (register-file read port 1)
busy  out  1  high while state is RUN or FIX
done  out  1  one-cycle pulse; result valid
result  out  XLEN  registered result; held stable from done until the next accepted start

Behaviour:
- Reset (rst_n low, asynchronous): state goes to IDLE; busy=0, done=0, result=0; all internal registers cleared. A reset mid-operation aborts the operation, and no done is produced.
- States:
  - IDLE: waiting for start.
  - RUN: iterating.
  - FIX: sign correction and result select.
  - DONE: done=1 for exactly one cycle.
- Accept: a posedge where start=1 and state is IDLE or DONE.
  - At that edge, latch funct3, |op_a| and |op_b| (magnitudes per the op signedness), and the result sign flags.
  - start in RUN or FIX is ignored; there is no queueing.
- Signedness:
  - MUL and MULH: both operands signed.
  - MULHSU: op_a signed, op_b unsigned.
  - MULHU and DIVU/REMU: unsigned.
  - DIV/REM: signed.
- Multiply: shift-add over a 2*XLEN product register, one bit per RUN cycle.
  - MUL returns the low XLEN bits of the product.
  - MULH* return the high XLEN bits.
  - The 2*XLEN product is negated in FIX when the sign flags differ.
- Divide: restoring division, one quotient bit per RUN cycle.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- Iteration counter runs 0..XLEN-1; RUN lasts exactly XLEN cycles.
- Normal latency, with the accept edge as edge 0:
  - Edges 1..XLEN perform the iterations; state becomes FIX at edge XLEN.
  - Edge XLEN+1 registers result and moves to DONE.
  - done is high in the cycle after edge XLEN+1, i.e. 34 cycles for XLEN=32.
- Fast paths (IDLE/DONE -> FIX directly at the accept edge; done after edge 1):
  - Divide by zero (op_b==0): DIV/DIVU give all ones; REM/REMU give op_a.
  - Signed overflow (DIV/REM with op_a=0x80000000, op_b=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
  - Multiply has no fast path, including a zero operand.
- DONE -> IDLE on the next edge, or -> RUN/FIX if start is accepted in DONE (back-to-back ops).
- result changes only at the FIX->DONE edge and at reset.

Decomposition:
- Shared package riscv_pkg holds:
  - the m_funct3_e enum (the 8 RV32M encodings);
  - the muldiv_state_e enum (IDLE, RUN, FIX, DONE);
  - the constant XLEN=32.
- Single module, no sub-module. The multiply and divide datapaths share the 2*XLEN accumulator and the counter.

Test Plan:
- Reset mid-RUN: start MUL 7*6, assert rst_n low at cycle 10 -> busy=0, done=0, result=0 immediately; no done afterwards.
- MUL a=0xFFFFFFFF (-1), b=5 -> result=0xFFFFFFFB; done exactly 34 cycles after the accept; busy high in cycles 1..33.
- MULH a=0x80000000, b=0x80000000 -> 0x40000000. MULHU on the same operands -> 0x40000000. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFD. REM on the same operands -> 0xFFFFFFFF. DIVU a=100, b=7 -> 14. REMU a=100, b=7 -> 2.
- Fast paths, each with done 2 cycles after the accept:
  - DIVU a=0x1234, b=0 -> 0xFFFFFFFF.
  - REM a=0x1234, b=0 -> 0x1234.
  - DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000.
- Back-to-back and ignored start:
  - start held high through RUN -> no effect on result.
  - start asserted in the DONE cycle -> the new op accepted at that edge; the previous result stays stable until the new FIX->DONE edge.
